data_memory: RTL and testbench



---
 rtl/data_memory_if.sv | 25 ++
 rtl/data_memory.sv | 37 +++
 tb/tb_data_memory.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// Data-memory access bus between the MEM stage and the word array.
// Combinational read path; writes commit on the clock edge; no handshake.
interface data_memory_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] Wd;
    logic [31:0] Rd;

    modport master (
        output MemRead,
        output MemWrite,
        output Addr,
        output Wd,
        input  Rd
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  Addr,
        input  Wd,
        output Rd
    );
endinterface

// File: rtl/data_memory.sv
// Word-wide data memory for the MEM stage: byte address in, 32-bit word out.
// Latency: write commits on the rising edge; read is combinational (zero cycles).
// Backpressure: none, every access completes in its cycle.
module data_memory #(
    parameter int WORDS = 64,
    parameter int IDX_W = 6
) (
    input  logic          Clk,
    input  logic          Rst,
    data_memory_if.slave  bus
);
    logic [31:0]      mem [WORDS];
    logic [IDX_W-1:0] idx;
    logic             unused_addr;

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign idx         = bus.Addr[IDX_W+1:2];
    assign unused_addr = ^{bus.Addr[31:IDX_W+2], bus.Addr[1:0]};

    // Reset wins over a simultaneous write; the write is dropped.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.MemWrite) begin
            mem[idx] <= bus.Wd;
        end
    end

    always_comb begin
        bus.Rd = '0;
        if (bus.MemRead) begin
            bus.Rd = mem[idx];
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_data_memory;
    logic Clk = 1'b0;
    logic Rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] model [64];

    always #5 Clk = ~Clk;

    data_memory_if bus();

    data_memory #(.WORDS(64), .IDX_W(6)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'd64);
    endfunction

    function automatic logic [31:0] ref_rd(input logic rd, input logic [31:0] a);
        return rd ? model[widx(a)] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and apply the memory's rules to the model.
    task automatic edge_step();
        @(posedge Clk);
        if (Rst) begin
            for (int i = 0; i < 64; i++) model[i] = 32'h0;
        end else if (bus.MemWrite) begin
            model[widx(bus.Addr)] = bus.Wd;
        end
        #1;
    endtask

    task automatic probe(input string tag, input logic rd, input logic [31:0] a,
                         input logic [31:0] exp);
        bus.MemRead = rd;
        bus.Addr    = a;
        #1;
        check(tag, bus.Rd, exp);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        Rst          = 1'b1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Addr     = 32'h0;
        bus.Wd       = 32'h0;
        edge_step();
        Rst = 1'b0;

        // Reset then read
        probe("rst_rd0",   1'b1, 32'd0,   32'h0);
        probe("rst_rd88",  1'b1, 32'd88,  32'h0);
        probe("rst_rd252", 1'b1, 32'd252, 32'h0);
        probe("rst_norm",  1'b0, 32'd88,  32'h0);

        // Write / readback
        bus.MemWrite = 1'b1;
        bus.Addr     = 32'd88;
        bus.Wd       = 32'h12345678;
        edge_step();
        bus.MemWrite = 1'b0;
        probe("wr_rb88",   1'b1, 32'd88,  32'h12345678);
        probe("wr_rdoff",  1'b0, 32'd88,  32'h0);
        probe("alias89",   1'b1, 32'd89,  32'h12345678);
        probe("alias91",   1'b1, 32'd91,  32'h12345678);
        probe("alias344",  1'b1, 32'd344, 32'h12345678);
        probe("nbr84",     1'b1, 32'd84,  32'h0);
        probe("nbr92",     1'b1, 32'd92,  32'h0);

        // Simultaneous read and write
        edge_step();
        bus.MemWrite = 1'b1;
        bus.Wd       = 32'hDEADBEEF;
        probe("rw_before", 1'b1, 32'd88,  32'h12345678);
        edge_step();
        bus.MemWrite = 1'b0;
        probe("rw_after",  1'b1, 32'd88,  32'hDEADBEEF);

        // Reset priority over write
        edge_step();
        Rst          = 1'b1;
        bus.MemWrite = 1'b1;
        bus.Addr     = 32'd4;
        bus.Wd       = 32'hA5A5A5A5;
        edge_step();
        Rst          = 1'b0;
        bus.MemWrite = 1'b0;
        probe("rstpri4",   1'b1, 32'd4,   32'h0);
        probe("rstpri88",  1'b1, 32'd88,  32'h0);

        // Full sweep
        for (int i = 0; i < 64; i++) begin
            bus.MemWrite = 1'b1;
            bus.Addr     = 32'(4 * i);
            bus.Wd       = 32'(i) * 32'h01010101;
            edge_step();
        end
        bus.MemWrite = 1'b0;
        for (int i = 0; i < 64; i++) begin
            probe($sformatf("sweep%0d", i), 1'b1, 32'(4 * i), 32'(i) * 32'h01010101);
        end

        // Randomized traffic against the model
        edge_step();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            Rst          = ($urandom_range(0, 99) < 3);
            bus.MemWrite = 1'($urandom_range(0, 1));
            bus.Wd       = $urandom;
            a            = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
            bus.Addr     = a;
            bus.MemRead  = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("rnd_pre%0d", n), bus.Rd, ref_rd(bus.MemRead, a));
            edge_step();
            check($sformatf("rnd_post%0d", n), bus.Rd, ref_rd(bus.MemRead, a));
            a        = $urandom;
            bus.Addr = a;
            #1;
            check($sformatf("rnd_any%0d", n), bus.Rd, ref_rd(bus.MemRead, a));
        end
        Rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
